// File: rtl/readout_pkg.sv
// Shared types and sizing helpers for the pixel readout sequencer.
package readout_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

    function automatic int cnt_width(input int settle);
        return (settle > 1) ? $clog2(settle) : 1;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_ROWS  = 2;
    localparam int DEF_COLS  = 2;
    localparam int ROW_IDX_W = idx_width(DEF_ROWS);
    localparam int COL_IDX_W = idx_width(DEF_COLS);

endpackage

// File: rtl/Graycounter_decode.sv
// Gray-to-binary decoder shared with the ADC gray counter.
module Graycounter_decode #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Each binary bit is the XOR of all gray bits at or above it.
    always_comb begin
        bin = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/readout_row_buffer.sv
// One row of decoded pixels with a capture strobe and column read mux.
// With READOUT_OFFSET_EN the black-level offset is subtracted (saturating) at capture.
module readout_row_buffer
    import readout_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int COLS  = 2,
    localparam int CIW  = idx_width(COLS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  capture,
    input  logic [COLS*WIDTH-1:0] row_bin,
`ifdef READOUT_OFFSET_EN
    input  logic [WIDTH-1:0]      offset,
`endif
    input  logic [CIW-1:0]        rd_col,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] buf_r [COLS];

    function automatic logic [WIDTH-1:0] sat_sub(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        return (a < b) ? {WIDTH{1'b0}} : (a - b);
    endfunction

    // Row storage: cleared by reset, loaded from the decoded column bus on capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < COLS; c++) begin
                buf_r[c] <= {WIDTH{1'b0}};
            end
        end else if (capture) begin
            for (int c = 0; c < COLS; c++) begin
`ifdef READOUT_OFFSET_EN
                buf_r[c] <= sat_sub(row_bin[c*WIDTH +: WIDTH], offset);
`else
                buf_r[c] <= row_bin[c*WIDTH +: WIDTH];
`endif
            end
        end
    end

    // Column read mux over registered data only.
    always_comb begin
        rd_data = {WIDTH{1'b0}};
        for (int c = 0; c < COLS; c++) begin
            if (rd_col == CIW'(c)) begin
                rd_data = buf_r[c];
            end else begin
                rd_data = rd_data;
            end
        end
    end

endmodule

// File: rtl/pixel_readout.sv
// Frame readout sequencer: selects rows, captures and gray-decodes columns, streams pixels.
// Optional black-level offset is enabled with the READOUT_OFFSET_EN macro.
module pixel_readout #(
    parameter int WIDTH  = 8,
    parameter int ROWS   = 2,
    parameter int COLS   = 2,
    parameter int SETTLE = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [ROWS-1:0]       row_sel,
    input  logic [COLS*WIDTH-1:0] col_data,
    output logic [WIDTH-1:0]      pix_data,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic                  pix_last,
`ifdef READOUT_OFFSET_EN
    input  logic [WIDTH-1:0]      offset,
`endif
    output logic                  busy
);

    localparam int CW  = readout_pkg::cnt_width(SETTLE);
    localparam int RW  = readout_pkg::idx_width(ROWS);
    localparam int CIW = readout_pkg::idx_width(COLS);

    readout_pkg::state_t   state_r;
    logic [RW-1:0]         row_r;
    logic [CIW-1:0]        col_r;
    logic [CW-1:0]         cnt_r;
    logic                  capture_s;
    logic [COLS*WIDTH-1:0] bin_row_s;
    logic [WIDTH-1:0]      rd_data_s;
`ifdef READOUT_OFFSET_EN
    logic [WIDTH-1:0]      offset_r;
`endif

    for (genvar g = 0; g < COLS; g++) begin : g_dec
        Graycounter_decode #(.WIDTH(WIDTH)) u_dec (
            .gray (col_data[g*WIDTH +: WIDTH]),
            .bin  (bin_row_s[g*WIDTH +: WIDTH])
        );
    end

    assign capture_s = (state_r == readout_pkg::SETTLE) && (cnt_r == {CW{1'b0}});

    readout_row_buffer #(.WIDTH(WIDTH), .COLS(COLS)) u_buf (
        .clk     (clk),
        .reset   (reset),
        .capture (capture_s),
        .row_bin (bin_row_s),
`ifdef READOUT_OFFSET_EN
        .offset  (offset_r),
`endif
        .rd_col  (col_r),
        .rd_data (rd_data_s)
    );

    // Only a held pixel is presented; otherwise the bus reads zero.
    assign pix_data = pix_valid ? rd_data_s : {WIDTH{1'b0}};

    // Sequencer FSM with registered row select, handshake and busy outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= readout_pkg::IDLE;
            row_r     <= {RW{1'b0}};
            col_r     <= {CIW{1'b0}};
            cnt_r     <= {CW{1'b0}};
            row_sel   <= {ROWS{1'b0}};
            pix_valid <= 1'b0;
            pix_last  <= 1'b0;
            busy      <= 1'b0;
`ifdef READOUT_OFFSET_EN
            offset_r  <= {WIDTH{1'b0}};
`endif
        end else begin
            case (state_r)
                readout_pkg::IDLE: begin
                    if (start) begin
                        state_r  <= readout_pkg::SETTLE;
                        row_r    <= {RW{1'b0}};
                        col_r    <= {CIW{1'b0}};
                        cnt_r    <= CW'(SETTLE - 1);
                        row_sel  <= ROWS'(1'b1);
                        busy     <= 1'b1;
`ifdef READOUT_OFFSET_EN
                        offset_r <= offset;
`endif
                    end
                end
                readout_pkg::SETTLE: begin
                    if (cnt_r == {CW{1'b0}}) begin
                        state_r   <= readout_pkg::STREAM;
                        col_r     <= {CIW{1'b0}};
                        row_sel   <= {ROWS{1'b0}};
                        pix_valid <= 1'b1;
                        pix_last  <= (row_r == RW'(ROWS - 1)) && (COLS == 1);
                    end else begin
                        cnt_r <= cnt_r - CW'(1'b1);
                    end
                end
                readout_pkg::STREAM: begin
                    if (pix_ready) begin
                        if (col_r != CIW'(COLS - 1)) begin
                            col_r    <= col_r + CIW'(1'b1);
                            pix_last <= (row_r == RW'(ROWS - 1)) && (col_r == CIW'(COLS - 2));
                        end else if (row_r != RW'(ROWS - 1)) begin
                            state_r   <= readout_pkg::SETTLE;
                            row_r     <= row_r + RW'(1'b1);
                            cnt_r     <= CW'(SETTLE - 1);
                            row_sel   <= ROWS'(1'b1) << (row_r + RW'(1'b1));
                            pix_valid <= 1'b0;
                            pix_last  <= 1'b0;
                        end else begin
                            state_r   <= readout_pkg::DONE;
                            pix_valid <= 1'b0;
                            pix_last  <= 1'b0;
                        end
                    end
                end
                readout_pkg::DONE: begin
                    state_r <= readout_pkg::IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r   <= readout_pkg::IDLE;
                    row_sel   <= {ROWS{1'b0}};
                    pix_valid <= 1'b0;
                    pix_last  <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
